// File: rtl/if_id_queue.sv
// IF->ID pipeline buffer: a DEPTH-entry circular queue of (pc, instruction) pairs
// with valid/ready on both sides, single-cycle flush and a NOP head when empty.
module if_id_queue #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INST_W   = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0013)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [PC_W-1:0]          in_pc_i,
  input  logic [INST_W-1:0]        in_inst_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [PC_W-1:0]          out_pc_o,
  output logic [INST_W-1:0]        out_inst_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("if_id_queue: DEPTH must be a power of two and at least 2");
  end

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push;
  logic             pop;

  // Both ready and valid come from the registered count alone, so there is no
  // combinational path across the queue in either direction.
  assign in_ready_o  = (count_q != FULL_CNT);
  assign out_valid_o = (count_q != '0);
  assign count_o     = count_q;

  assign push = in_valid_i  & in_ready_o  & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  // Control state. rst_n is active-high here despite its name.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q gates every read, so stale data is never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{pc: in_pc_i, inst: in_inst_i};
  end

  // NOTE: defaults are assigned first so no path through the block can infer a latch.
  always_comb begin
    out_pc_o   = '0;
    out_inst_o = NOP_INST;
    if (out_valid_o) begin
      out_pc_o   = mem[rd_ptr_q].pc;
      out_inst_o = mem[rd_ptr_q].inst;
    end
  end

endmodule
